opponent_link_tx: RTL and testbench

// - Outbound half of the board-to-board link: takes the per-frame player snapshot (data_t, 89 b)

---
 rtl/opponent_link_tx_if.sv | 31 +++
 rtl/opponent_link_tx.sv | 210 +++++++++++++++++++++
 tb/tb_opponent_link_tx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/opponent_link_tx_if.sv
// Board-to-board link transmit interface: snapshot strobe in, serial line and status out.
// The master drives snapshots; the slave (transmitter) drives the line and status.
interface opponent_link_tx_if;
    logic [88:0] data_in;
    logic        scored_in;
    logic        data_in_valid;
    logic        tx_out;
    logic        busy_out;
    logic        frame_sent_out;
    logic        dropped_out;

    modport master (
        output data_in,
        output scored_in,
        output data_in_valid,
        input  tx_out,
        input  busy_out,
        input  frame_sent_out,
        input  dropped_out
    );

    modport slave (
        input  data_in,
        input  scored_in,
        input  data_in_valid,
        output tx_out,
        output busy_out,
        output frame_sent_out,
        output dropped_out
    );
endinterface

// File: rtl/opponent_link_tx.sv
// Serialises player snapshot + scored flag onto the opponent link wire.
// LINK_CRC_EN selects a CRC-8 check field instead of a single even-parity bit.
module opponent_link_tx #(
    parameter int         CYCLES_PER_BIT = 64,
    parameter int         GAP_BITS       = 4,
    parameter logic [7:0] PREAMBLE       = 8'hA5
) (
    input  logic         clk_pixel_in,
    input  logic         rst_n_in,
    opponent_link_tx_if.slave link
);
    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_PRE  = CW'(CYCLES_PER_BIT - 2);
    localparam logic [6:0]    GAP_LAST = 7'(GAP_BITS - 1);
    localparam logic [6:0]    PRE_LAST = 7'd7;
    localparam logic [6:0]    PAY_LAST = 7'd89;
`ifdef LINK_CRC_EN
    localparam logic [6:0]    CHK_LAST = 7'd7;
`else
    localparam logic [6:0]    CHK_LAST = 7'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PREAMBLE,
        S_PAYLOAD,
        S_CHECK,
        S_STOP,
        S_GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [6:0]    bit_cnt;
    logic [97:0]   sr;
    logic [7:0]    chk;
    logic          tx_q;
    logic          busy_q;
    logic          sent_q;
    logic          drop_q;
    logic          pend_full;
    logic [88:0]   pend_data;
    logic          pend_scored;

    logic          bit_end;
    logic          gap_last;
    logic          load_now;
    logic          eff_full;
    logic [88:0]   eff_data;
    logic          eff_scored;
    logic [7:0]    chk_next;
    logic          chk_first;
    logic [7:0]    chk_after;

    assign link.tx_out         = tx_q;
    assign link.busy_out       = busy_q;
    assign link.frame_sent_out = sent_q;
    assign link.dropped_out    = drop_q;

    always_comb begin
        bit_end  = (cyc == CYC_LAST);
        gap_last = (state == S_GAP) && bit_end
                && (bit_cnt == GAP_LAST);
        eff_full = pend_full | link.data_in_valid;
        eff_data = link.data_in_valid ? link.data_in
                                      : pend_data;
        // a queued score survives being overwritten
        eff_scored = link.data_in_valid
                   ? (link.scored_in | (pend_full & pend_scored))
                   : pend_scored;
        load_now = eff_full
                && ((state == S_IDLE) || gap_last);
`ifdef LINK_CRC_EN
        chk_next  = {chk[6:0], 1'b0}
                  ^ ({8{chk[7] ^ sr[0]}} & 8'h07);
        chk_first = chk[7];
        chk_after = {chk[6:0], 1'b0};
`else
        chk_next  = {chk[7:1], chk[0] ^ sr[0]};
        chk_first = chk[0];
        chk_after = chk;
`endif
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= S_IDLE;
            cyc         <= '0;
            bit_cnt     <= '0;
            sr          <= '0;
            chk         <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            drop_q      <= 1'b0;
            pend_full   <= 1'b0;
            pend_data   <= '0;
            pend_scored <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            drop_q <= link.data_in_valid & pend_full;

            if (load_now) begin
                pend_full <= 1'b0;
            end else if (link.data_in_valid) begin
                pend_full   <= 1'b1;
                pend_data   <= eff_data;
                pend_scored <= eff_scored;
            end

            if (bit_end || state == S_IDLE) begin
                cyc <= '0;
            end else begin
                cyc <= cyc + 1'b1;
            end

            if (load_now) begin
                state   <= S_START;
                tx_q    <= 1'b0;
                busy_q  <= 1'b1;
                sr      <= {eff_scored, eff_data, PREAMBLE};
                chk     <= '0;
                bit_cnt <= '0;
                cyc     <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            state   <= S_PREAMBLE;
                            bit_cnt <= '0;
                            tx_q    <= sr[0];
                            sr      <= sr >> 1;
                        end
                    end
                    S_PREAMBLE: begin
                        if (bit_end) begin
                            tx_q <= sr[0];
                            sr   <= sr >> 1;
                            if (bit_cnt == PRE_LAST) begin
                                state   <= S_PAYLOAD;
                                bit_cnt <= '0;
                                chk     <= chk_next;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (bit_end) begin
                            if (bit_cnt == PAY_LAST) begin
                                state   <= S_CHECK;
                                bit_cnt <= '0;
                                tx_q    <= chk_first;
                                chk     <= chk_after;
                            end else begin
                                tx_q    <= sr[0];
                                sr      <= sr >> 1;
                                chk     <= chk_next;
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (bit_end) begin
                            if (bit_cnt == CHK_LAST) begin
                                state   <= S_STOP;
                                bit_cnt <= '0;
                                tx_q    <= 1'b1;
                            end else begin
                                tx_q    <= chk[7];
                                chk     <= {chk[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end
                    S_STOP: begin
                        if (cyc == CYC_PRE) begin
                            sent_q <= 1'b1;
                        end
                        if (bit_end) begin
                            state   <= S_GAP;
                            bit_cnt <= '0;
                        end
                    end
                    S_GAP: begin
                        if (bit_end) begin
                            if (bit_cnt == GAP_LAST) begin
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_opponent_link_tx.sv
// Directed + random checks of opponent_link_tx against a frame-level model.
// Build with LINK_CRC_EN defined to exercise the CRC-8 check field.
module tb_opponent_link_tx;
    localparam int CPB = 4;
    localparam int GAP = 2;
    localparam logic [7:0] PRE = 8'hA5;
`ifdef LINK_CRC_EN
    localparam int FLEN = 108;
`else
    localparam int FLEN = 101;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   fs_cnt;
    int   drop_cnt;

    opponent_link_tx_if link ();

    opponent_link_tx #(
        .CYCLES_PER_BIT(CPB),
        .GAP_BITS(GAP),
        .PREAMBLE(PRE)
    ) dut (
        .clk_pixel_in(clk),
        .rst_n_in(rst_n),
        .link(link.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (link.frame_sent_out === 1'b1) fs_cnt++;
        if (link.dropped_out === 1'b1) drop_cnt++;
    end

    function automatic logic [127:0] frame_bits(input logic [89:0] p);
        logic [127:0] f;
        logic [7:0]   c;
        logic         fb;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = PRE[i];
        for (int i = 0; i < 90; i++) f[9+i] = p[i];
`ifdef LINK_CRC_EN
        c = 8'h00;
        for (int i = 0; i < 90; i++) begin
            fb = c[7] ^ p[i];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        for (int i = 0; i < 8; i++) f[99+i] = c[7-i];
        f[107] = 1'b1;
`else
        c = 8'h00;
        f[99] = ^p;
        f[100] = 1'b1;
`endif
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [88:0] d, input logic s);
        link.data_in       = d;
        link.scored_in     = s;
        link.data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        link.data_in_valid = 1'b0;
    endtask

    // walks the whole frame plus gap, one sample per cycle
    task automatic check_frame(input logic [89:0] p);
        logic [127:0] f;
        int fs0;
        f = frame_bits(p);
        fs0 = fs_cnt;
        for (int k = 0; k < FLEN * CPB; k++) begin
            @(negedge clk);
            chk("tx_bit", link.tx_out, f[k/CPB]);
            chk("busy_frame", link.busy_out, 1);
            chk("frame_sent", link.frame_sent_out, k == FLEN*CPB-1);
        end
        for (int g = 0; g < GAP * CPB; g++) begin
            @(negedge clk);
            chk("gap_tx", link.tx_out, 1);
            chk("gap_busy", link.busy_out, 1);
        end
        chk("sent_once", fs_cnt - fs0, 1);
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx", link.tx_out, 1);
            chk("idle_busy", link.busy_out, 0);
        end
    endtask

    function automatic logic [88:0] rnd89();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[88:0];
    endfunction

    initial begin
        logic [88:0] a, b, c, d;
        logic        sa;
        int          fs0, dr0;
        errors = 0;
        checks = 0;
        fs_cnt = 0;
        drop_cnt = 0;
        rst_n = 1'b0;
        link.data_in = '0;
        link.scored_in = 1'b0;
        link.data_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", link.tx_out, 1);
        chk("rst_busy", link.busy_out, 0);
        chk("rst_sent", link.frame_sent_out, 0);
        chk("rst_drop", link.dropped_out, 0);
        rst_n = 1'b1;
        check_idle(5);

        // single directed frame
        @(posedge clk); #1;
        pulse(89'h1, 1'b1);
        check_frame({1'b1, 89'h1});
        check_idle(4);

        // random single frames
        for (int n = 0; n < 3; n++) begin
            a = rnd89();
            sa = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            pulse(a, sa);
            check_frame({sa, a});
            check_idle(3);
        end

        // back-to-back: B queued 10 cycles after A
        a = rnd89();
        b = rnd89();
        dr0 = drop_cnt;
        @(posedge clk); #1;
        pulse(a, 1'b0);
        fork
            check_frame({1'b0, a});
            begin
                repeat (9) @(posedge clk);
                #1;
                pulse(b, 1'b1);
            end
        join
        check_frame({1'b1, b});
        check_idle(3);
        chk("b2b_no_drop", drop_cnt - dr0, 0);

        // overwrite: B(scored) then C(unscored) while A airs
        a = rnd89();
        b = rnd89();
        c = rnd89();
        dr0 = drop_cnt;
        @(posedge clk); #1;
        pulse(a, 1'b0);
        fork
            check_frame({1'b0, a});
            begin
                repeat (30) @(posedge clk);
                #1;
                pulse(b, 1'b1);
                repeat (20) @(posedge clk);
                #1;
                pulse(c, 1'b0);
            end
        join
        check_frame({1'b1, c});
        check_idle(3);
        chk("overwrite_drop", drop_cnt - dr0, 1);

        // strobe lands on the last gap cycle
        a = rnd89();
        d = rnd89();
        @(posedge clk); #1;
        pulse(a, 1'b1);
        check_frame({1'b1, a});
        fs0 = fs_cnt;
        pulse(d, 1'b0);
        check_frame({1'b0, d});
        check_idle(20);
        chk("boundary_one_frame", fs_cnt - fs0, 1);

        // reset in the middle of the payload
        a = rnd89();
        @(posedge clk); #1;
        pulse(a, 1'b1);
        repeat (60) @(negedge clk);
        chk("mid_busy", link.busy_out, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx", link.tx_out, 1);
        chk("arst_busy", link.busy_out, 0);
        chk("arst_sent", link.frame_sent_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fs0 = fs_cnt;
        check_idle(500);
        chk("post_rst_no_sent", fs_cnt - fs0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
